key_event_decoder: RTL and testbench

Classifies debounced key activity into gesture events: single click, double click, long press and auto-repeat while held. It sits directly downstream of the key debouncer and consumes that block's one-cycle `key_flag` strobe and its registered `key_value` level (0 = pressed, 1 = released). Its outputs are one-cycle pulses that drive application logic such as mode select or parameter increment.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_event_decoder.sv | 101 ++++++++++
 tb/tb_key_event_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared key timing definitions: FSM state encoding and default gesture counts
// used by both the debouncer and the gesture decoder.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } key_state_t;

    // Defaults assume a 50 MHz system clock
    localparam logic [31:0] DEF_LONG_CNT   = 32'd50_000_000;
    localparam logic [31:0] DEF_DBL_CNT    = 32'd15_000_000;
    localparam logic [31:0] DEF_REPEAT_CNT = 32'd10_000_000;

endpackage

// File: rtl/key_event_decoder.sv
// Turns debounced key press/release strobes into click, double-click,
// long-press and auto-repeat pulses.
module key_event_decoder
    import key_pkg::*;
#(
    parameter logic [31:0] LONG_CNT   = DEF_LONG_CNT,
    parameter logic [31:0] DBL_CNT    = DEF_DBL_CNT,
    parameter logic [31:0] REPEAT_CNT = DEF_REPEAT_CNT
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    input  logic key_value,
    output logic click_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    key_state_t  state;
    key_state_t  state_nxt;
    logic [31:0] cnt;
    logic        press_ev;
    logic        release_ev;
    logic        long_hit;
    logic        dbl_hit;
    logic        rep_hit;
    logic        timed;
    logic        cnt_clr;
    logic        click_nxt;
    logic        double_nxt;
    logic        long_nxt;
    logic        repeat_nxt;

    assign press_ev   = key_flag & ~key_value;
    assign release_ev = key_flag &  key_value;
    assign long_hit   = (cnt == LONG_CNT - 32'd1);
    assign dbl_hit    = (cnt == DBL_CNT - 32'd1);
    assign rep_hit    = (cnt == REPEAT_CNT - 32'd1);
    assign timed      = (state == PRESS1) || (state == LONG) || (state == WAIT2);
    // A repeat tick restarts the period without leaving LONG
    assign cnt_clr    = (state_nxt != state) || repeat_nxt;
    assign busy       = (state != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            click_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            click_pulse  <= click_nxt;
            double_pulse <= double_nxt;
            long_pulse   <= long_nxt;
            repeat_pulse <= repeat_nxt;
            if (cnt_clr) begin
                cnt <= 32'd0;
            end else if (timed) begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    // Key events take priority over a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (press_ev) state_nxt = PRESS1;
            PRESS1: begin
                if (release_ev)    state_nxt = WAIT2;
                else if (long_hit) state_nxt = LONG;
            end
            LONG:    if (release_ev) state_nxt = IDLE;
            WAIT2: begin
                if (press_ev)      state_nxt = PRESS2;
                else if (dbl_hit)  state_nxt = IDLE;
            end
            PRESS2:  if (release_ev) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        click_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        case (state)
            PRESS1:  long_nxt   = ~release_ev & long_hit;
            LONG:    repeat_nxt = ~release_ev & rep_hit;
            WAIT2:   click_nxt  = ~press_ev & dbl_hit;
            PRESS2:  double_nxt = release_ev;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized gesture bench: expected pulse times and busy windows are computed
// from gesture timing rules and compared with what the decoder emits.
module tb_key_event_decoder;

    localparam int LONG = 100;
    localparam int DBL  = 40;
    localparam int REP  = 20;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    logic key_flag  = 1'b0;
    logic key_value = 1'b1;
    logic click_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int at;
        int kind;
    } pulse_t;

    typedef struct {
        int lo;
        int hi;
    } span_t;

    pulse_t exp_q[$];
    pulse_t act_q[$];
    span_t  busy_q[$];

    key_event_decoder #(
        .LONG_CNT   (32'd100),
        .DBL_CNT    (32'd40),
        .REPEAT_CNT (32'd20)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_flag     (key_flag),
        .key_value    (key_value),
        .click_pulse  (click_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int busy_model(input int k);
        foreach (busy_q[i]) begin
            if (busy_q[i].lo <= k && k < busy_q[i].hi) return 1;
        end
        return 0;
    endfunction

    // Pulse codes: 0 click, 1 double, 2 long, 3 repeat
    always @(negedge sys_clk) begin
        int n;
        n = int'(click_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse);
        chk("onehot", int'(n > 1), 0);
        chk("busy", int'(busy), busy_model(cyc));
        if (click_pulse)  act_q.push_back('{cyc, 0});
        if (double_pulse) act_q.push_back('{cyc, 1});
        if (long_pulse)   act_q.push_back('{cyc, 2});
        if (repeat_pulse) act_q.push_back('{cyc, 3});
    end

    task automatic drive(input logic f, input logic v);
        key_flag  = f;
        key_value = v;
        @(posedge sys_clk);
        #1;
    endtask

    // Idle/hold cycles, sprinkled with events repeating the current level
    task automatic hold(input int n, input logic lvl);
        for (int i = 0; i < n; i++) drive($urandom_range(7) == 0, lvl);
    endtask

    task automatic g_single(input int h, input int gap);
        int s;
        s = cyc + 1;
        exp_q.push_back('{s + h + DBL, 0});
        busy_q.push_back('{s, s + h + DBL});
        drive(1'b1, 1'b0);
        hold(h - 1, 1'b0);
        drive(1'b1, 1'b1);
        hold(gap - 1, 1'b1);
    endtask

    task automatic g_double(input int h1, input int g, input int h2, input int gap);
        int s;
        int r2;
        s  = cyc + 1;
        r2 = s + h1 + g + h2;
        exp_q.push_back('{r2, 1});
        busy_q.push_back('{s, r2});
        drive(1'b1, 1'b0);
        hold(h1 - 1, 1'b0);
        drive(1'b1, 1'b1);
        hold(g - 1, 1'b1);
        drive(1'b1, 1'b0);
        hold(h2 - 1, 1'b0);
        drive(1'b1, 1'b1);
        hold(gap - 1, 1'b1);
    endtask

    task automatic g_long(input int h, input int gap);
        int s;
        s = cyc + 1;
        exp_q.push_back('{s + LONG, 2});
        for (int t = s + LONG + REP; t < s + h; t += REP) exp_q.push_back('{t, 3});
        busy_q.push_back('{s, s + h});
        drive(1'b1, 1'b0);
        hold(h - 1, 1'b0);
        drive(1'b1, 1'b1);
        hold(gap - 1, 1'b1);
    endtask

    // Reset lands in WAIT2 with the count at 20; the pending click must vanish
    task automatic g_reset_mid;
        int s;
        s = cyc + 1;
        busy_q.push_back('{s, s + 10 + 20});
        drive(1'b1, 1'b0);
        hold(9, 1'b0);
        drive(1'b1, 1'b1);
        hold(20, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_click", int'(click_pulse), 0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        sys_rst_n = 1'b1;
        hold(3, 1'b1);
    endtask

    initial begin
        int k;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_busy",   int'(busy), 0);
        chk("rst_click",  int'(click_pulse), 0);
        chk("rst_double", int'(double_pulse), 0);
        chk("rst_long",   int'(long_pulse), 0);
        chk("rst_repeat", int'(repeat_pulse), 0);
        sys_rst_n = 1'b1;
        hold(5, 1'b1);

        g_single(10, 45);
        g_double(10, 15, 10, 5);
        g_long(165, 5);
        g_single(100, 41);
        g_double(10, 40, 10, 1);
        g_single(1, 41);
        g_long(101, 1);
        g_long(120, 3);
        g_double(1, 1, 150, 2);
        g_reset_mid();
        g_single(10, 45);

        for (int i = 0; i < 30; i++) begin
            k = int'($urandom_range(2));
            case (k)
                0: g_single(int'($urandom_range(100, 1)), int'($urandom_range(60, 41)));
                1: g_double(int'($urandom_range(100, 1)), int'($urandom_range(40, 1)),
                            int'($urandom_range(150, 1)), int'($urandom_range(10, 1)));
                default: g_long(int'($urandom_range(190, 101)), int'($urandom_range(10, 1)));
            endcase
        end
        hold(60, 1'b1);

        chk("pulse_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("pulse%0d_at", i),   act_q[i].at,   exp_q[i].at);
            chk($sformatf("pulse%0d_kind", i), act_q[i].kind, exp_q[i].kind);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
